// File: rtl/usb_rx_if.sv
// ---------------------------------------------------------------------------
// usb_rx_if
// Bundles the pad-side line inputs, the RX FIFO handshake and the status
// outputs of the USB receive core.
//   dplus_in / dminus_in     : D+/D- line pair, synchronous to clk
//   buffer_occupancy[6:0]    : current RX FIFO byte count (0..64)
//   rx_packet_data[7:0]      : last completed payload byte
//   store_rx_packet_data     : one-cycle FIFO write strobe
//   flush                    : one-cycle FIFO clear request
//   rx_error                 : packet error flag (level)
//   rx_transfer_active       : high while a packet is being received
//   rx_data_ready            : valid packet completed (level)
//   rx_packet[3:0]           : PID of the last valid packet
// master = environment (pads + FIFO + controller), slave = receive core.
// ---------------------------------------------------------------------------
interface usb_rx_if;
  logic       dplus_in;
  logic       dminus_in;
  logic [6:0] buffer_occupancy;
  logic [7:0] rx_packet_data;
  logic       store_rx_packet_data;
  logic       flush;
  logic       rx_error;
  logic       rx_transfer_active;
  logic       rx_data_ready;
  logic [3:0] rx_packet;

  modport master (
    output dplus_in, dminus_in, buffer_occupancy,
    input  rx_packet_data, store_rx_packet_data, flush, rx_error,
           rx_transfer_active, rx_data_ready, rx_packet
  );

  modport slave (
    input  dplus_in, dminus_in, buffer_occupancy,
    output rx_packet_data, store_rx_packet_data, flush, rx_error,
           rx_transfer_active, rx_data_ready, rx_packet
  );
endinterface

// File: rtl/usb_rx_core.sv
// ---------------------------------------------------------------------------
// usb_rx_core
// Full-speed-style USB packet receiver, one bit time per clk. Decodes the
// NRZI line pair, removes stuffed bits, recognises SYNC / PID / payload / EOP,
// pushes payload bytes into the RX FIFO and reports packet status.
// Ports:
//   clk    : system clock, one bit time per rising edge
//   n_rst  : asynchronous active-low reset
//   bus    : usb_rx_if.slave (line pair, FIFO handshake, status outputs)
// Parameter:
//   MAX_BYTES : maximum payload bytes stored per packet (FIFO depth)
// ---------------------------------------------------------------------------
module usb_rx_core #(
  parameter int MAX_BYTES = 64
) (
  input  logic     clk,
  input  logic     n_rst,
  usb_rx_if.slave  bus
);

  localparam int CW = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_EOP, S_ERR_WAIT
  } state_t;

  state_t          r_state;
  logic            r_prev_dp;
  logic            r_prev_dm;
  logic [2:0]      r_zero_cnt;     // SYNC zeros, saturates at 5
  logic [2:0]      r_ones_cnt;     // consecutive decoded 1s for unstuffing
  logic [2:0]      r_bit_cnt;      // bits of the current byte
  logic [6:0]      r_shift;        // LSB-first byte assembly (bits 7..1)
  logic [CW-1:0]   r_byte_cnt;     // bytes stored in this packet
  logic            r_se0_long;     // EOP: second SE0 already seen
  logic            r_wait_se0;     // ERR_WAIT: SE0 already seen
  logic [2:0]      r_j_cnt;        // ERR_WAIT: consecutive J samples

  logic [7:0]      r_rx_packet_data;
  logic            r_store;
  logic            r_flush;
  logic            r_rx_error;
  logic            r_active;
  logic            r_ready;
  logic [3:0]      r_rx_packet;

  logic            w_se0, w_j, w_k;
  logic            w_bit;
  logic            w_stuff_slot;
  logic            w_stuff_err;
  logic            w_last;
  logic [7:0]      w_byte;
  logic            w_handshake;
  logic            w_room;
  logic            w_err;

  function automatic logic pid_ok(input logic [7:0] b);
    logic ok;
    case (b[3:0])
      4'b0001, 4'b1001, 4'b0011, 4'b1011,
      4'b0010, 4'b1010, 4'b1110: ok = (b[7:4] == ~b[3:0]);
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign w_se0 = !bus.dplus_in && !bus.dminus_in;
  assign w_j   =  bus.dplus_in && !bus.dminus_in;
  assign w_k   = !bus.dplus_in &&  bus.dminus_in;

  // NRZI: an unchanged line state decodes as 1, a transition as 0.
  assign w_bit = (bus.dplus_in == r_prev_dp) && (bus.dminus_in == r_prev_dm);

  // After six 1s the next bit is a stuffed 0 and carries no data.
  assign w_stuff_slot = (r_ones_cnt == 3'd6);
  assign w_stuff_err  = !w_se0 && w_stuff_slot && w_bit;
  assign w_last       = !w_se0 && !w_stuff_slot && (r_bit_cnt == 3'd7);
  assign w_byte       = {w_bit, r_shift};

  assign w_handshake = (r_rx_packet == 4'b0010) || (r_rx_packet == 4'b1010) ||
                       (r_rx_packet == 4'b1110);
  assign w_room      = (bus.buffer_occupancy < 7'd64) &&
                       (r_byte_cnt < CW'(MAX_BYTES));

  // Any error condition for this sample; takes precedence over every other
  // action, so a byte completing on a stuff error is never strobed.
  always_comb begin
    // NOTE: default first so every path assigns w_err and no latch is inferred.
    w_err = 1'b0;
    case (r_state)
      S_SYNC: w_err = w_se0 || (w_bit && (r_zero_cnt < 3'd5));
      S_PID:  w_err = w_se0 || w_stuff_err || (w_last && !pid_ok(w_byte));
      S_DATA: w_err = (w_se0 && (r_bit_cnt != 3'd0)) || w_stuff_err ||
                      (w_last && (w_handshake || !w_room));
      S_EOP:  w_err = !w_se0 && !(w_j && r_se0_long);
      default: w_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state          <= S_IDLE;
      r_prev_dp        <= 1'b1;       // idle J
      r_prev_dm        <= 1'b0;
      r_zero_cnt       <= '0;
      r_ones_cnt       <= '0;
      r_bit_cnt        <= '0;
      r_shift          <= '0;
      r_byte_cnt       <= '0;
      r_se0_long       <= 1'b0;
      r_wait_se0       <= 1'b0;
      r_j_cnt          <= '0;
      r_rx_packet_data <= '0;
      r_store          <= 1'b0;
      r_flush          <= 1'b0;
      r_rx_error       <= 1'b0;
      r_active         <= 1'b0;
      r_ready          <= 1'b0;
      r_rx_packet      <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      r_prev_dp <= bus.dplus_in;
      r_prev_dm <= bus.dminus_in;
      r_store   <= 1'b0;
      r_flush   <= 1'b0;

      if (w_err) begin
        r_state    <= S_ERR_WAIT;
        r_rx_error <= 1'b1;
        r_active   <= 1'b0;
        r_ready    <= 1'b0;
        r_wait_se0 <= w_se0;
        r_j_cnt    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_k) begin
              r_state    <= S_SYNC;
              r_rx_error <= 1'b0;
              r_ready    <= 1'b0;
              r_active   <= 1'b1;
              r_flush    <= (bus.buffer_occupancy != 7'd0);
              r_zero_cnt <= 3'd1;     // the first K is itself a decoded 0
            end
          end

          S_SYNC: begin
            if (!w_bit) begin
              if (r_zero_cnt < 3'd5) r_zero_cnt <= r_zero_cnt + 3'd1;
            end else begin
              r_state    <= S_PID;
              r_ones_cnt <= '0;
              r_bit_cnt  <= '0;
            end
          end

          S_PID, S_DATA: begin
            if (w_se0) begin
              // Only reachable from DATA on a byte boundary.
              r_state    <= S_EOP;
              r_se0_long <= 1'b0;
            end else if (w_stuff_slot) begin
              r_ones_cnt <= '0;
            end else begin
              r_ones_cnt <= w_bit ? r_ones_cnt + 3'd1 : 3'd0;
              r_shift    <= w_byte[7:1];
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (w_last) begin
                if (r_state == S_PID) begin
                  r_rx_packet <= w_byte[3:0];
                  r_byte_cnt  <= '0;
                  r_state     <= S_DATA;
                end else begin
                  r_rx_packet_data <= w_byte;
                  r_store          <= 1'b1;
                  r_byte_cnt       <= r_byte_cnt + CW'(1);
                end
              end
            end
          end

          S_EOP: begin
            if (w_se0) begin
              r_se0_long <= 1'b1;
            end else begin
              r_ready  <= 1'b1;
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end
          end

          S_ERR_WAIT: begin
            if (w_se0) begin
              r_wait_se0 <= 1'b1;
              r_j_cnt    <= '0;
            end else if (w_j) begin
              if (r_wait_se0 || (r_j_cnt == 3'd7)) r_state <= S_IDLE;
              else                                 r_j_cnt <= r_j_cnt + 3'd1;
            end else begin
              r_j_cnt <= '0;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rx_packet_data       = r_rx_packet_data;
  assign bus.store_rx_packet_data = r_store;
  assign bus.flush                = r_flush;
  assign bus.rx_error             = r_rx_error;
  assign bus.rx_transfer_active   = r_active;
  assign bus.rx_data_ready        = r_ready;
  assign bus.rx_packet            = r_rx_packet;

endmodule

// File: tb/tb_usb_rx_core.sv
// ---------------------------------------------------------------------------
// tb_usb_rx_core
// Self-checking bench for usb_rx_core. Packets are described as bit lists,
// NRZI-encoded with bit stuffing into line states, and the expected outcome
// (stored bytes, flags, PID) is derived from the packet description alone.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usb_rx_core;
  localparam int MAX_BYTES = 64;
  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;
  localparam logic [3:0] VALID_PIDS [7] = '{4'b0001, 4'b1001, 4'b0011, 4'b1011,
                                            4'b0010, 4'b1010, 4'b1110};

  logic clk = 1'b0;
  logic n_rst;
  usb_rx_if bus ();

  usb_rx_core #(.MAX_BYTES(MAX_BYTES)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed activity during a packet
  byte unsigned got_q[$];
  int           flush_cnt;
  bit           saw_active;

  always @(negedge clk) begin
    if (bus.store_rx_packet_data === 1'b1) got_q.push_back(bus.rx_packet_data);
    if (bus.flush === 1'b1) flush_cnt++;
    if (bus.rx_transfer_active === 1'b1) saw_active = 1'b1;
  end

  // Reference model state
  logic [1:0]   line_q[$];
  byte unsigned pay_q[$];
  byte unsigned exp_q[$];
  bit           exp_err;
  bit           exp_ready;
  int           exp_flush;
  logic [3:0]   exp_packet;

  function automatic logic [1:0] flip(input logic [1:0] s);
    return (s == LJ) ? LK : LJ;
  endfunction

  // Encode a packet into line_q and derive the expected outcome.
  task automatic build_packet(input logic [3:0] pid, input logic [3:0] chk,
                              input int sync0, input int extra_bits,
                              input bit omit_stuff, input int se0_len,
                              input logic [6:0] occ);
    bit         bits_q[$];
    logic [1:0] cur;
    int         ones;
    int         viol;
    bit         valid;
    bit         hs;
    bits_q.delete();
    line_q.delete();
    for (int b = 0; b < 4; b++) bits_q.push_back(pid[b]);
    for (int b = 0; b < 4; b++) bits_q.push_back(chk[b]);
    foreach (pay_q[i]) for (int b = 0; b < 8; b++) bits_q.push_back(pay_q[i][b]);
    for (int b = 0; b < extra_bits; b++) bits_q.push_back(1'($urandom_range(0, 1)));

    cur = LJ;
    repeat (4) line_q.push_back(LJ);
    for (int i = 0; i < sync0; i++) begin
      cur = flip(cur);
      line_q.push_back(cur);
    end
    line_q.push_back(cur);                 // closing '1' of SYNC
    ones = 0;
    viol = -1;
    for (int j = 0; j < bits_q.size(); j++) begin
      if (!bits_q[j]) cur = flip(cur);
      line_q.push_back(cur);
      ones = bits_q[j] ? ones + 1 : 0;
      if (ones == 6) begin
        if (omit_stuff) begin
          if (viol < 0 && j + 1 < bits_q.size() && bits_q[j+1]) viol = j + 1;
        end else begin
          cur = flip(cur);
          line_q.push_back(cur);
        end
        ones = 0;
      end
    end
    repeat (se0_len) line_q.push_back(LSE0);
    repeat (13) line_q.push_back(LJ);

    valid = 1'b0;
    foreach (VALID_PIDS[k]) if (VALID_PIDS[k] == pid) valid = 1'b1;
    valid = valid && (chk == ~pid);
    hs = (pid == 4'b0010) || (pid == 4'b1010) || (pid == 4'b1110);
    exp_q.delete();
    exp_err = 1'b0;
    if (viol >= 0 && viol < 8) exp_err = 1'b1;
    else if (!valid) exp_err = 1'b1;
    else begin
      exp_packet = pid;
      foreach (pay_q[i]) begin
        if (!exp_err) begin
          if (viol >= 0 && viol <= 8 * i + 15) exp_err = 1'b1;
          else if (hs || occ >= 7'd64 || i >= MAX_BYTES) exp_err = 1'b1;
          else exp_q.push_back(pay_q[i]);
        end
      end
      if (!exp_err && (viol >= 0 || extra_bits != 0 || se0_len < 2)) exp_err = 1'b1;
    end
    exp_ready = !exp_err;
    exp_flush = (occ != 7'd0) ? 1 : 0;
  endtask

  task automatic drive_lines(input int n);
    for (int i = 0; i < n && i < line_q.size(); i++) begin
      @(negedge clk);
      bus.dplus_in  = line_q[i][1];
      bus.dminus_in = line_q[i][0];
    end
  endtask

  // Send one packet and compare every observable result with the model.
  task automatic run_packet(input string name, input logic [3:0] pid,
                            input logic [3:0] chk, input int sync0,
                            input int extra_bits, input bit omit_stuff,
                            input int se0_len, input logic [6:0] occ);
    build_packet(pid, chk, sync0, extra_bits, omit_stuff, se0_len, occ);
    bus.buffer_occupancy = occ;
    got_q.delete();
    flush_cnt  = 0;
    saw_active = 1'b0;
    drive_lines(line_q.size());
    @(negedge clk);

    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s strobe_count got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s byte[%0d] got %02h expected %02h", name, i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (flush_cnt != exp_flush) begin
      n_bad++;
      $display("FAIL %s flush_pulses got %0d expected %0d", name, flush_cnt, exp_flush);
    end
    n_cmp++;
    if (bus.rx_error !== exp_err) begin
      n_bad++;
      $display("FAIL %s rx_error got %b expected %b", name, bus.rx_error, exp_err);
    end
    n_cmp++;
    if (bus.rx_data_ready !== exp_ready) begin
      n_bad++;
      $display("FAIL %s rx_data_ready got %b expected %b", name, bus.rx_data_ready, exp_ready);
    end
    n_cmp++;
    if (bus.rx_packet !== exp_packet) begin
      n_bad++;
      $display("FAIL %s rx_packet got %b expected %b", name, bus.rx_packet, exp_packet);
    end
    n_cmp++;
    if (bus.rx_transfer_active !== 1'b0) begin
      n_bad++;
      $display("FAIL %s rx_transfer_active_after got %b expected 0", name, bus.rx_transfer_active);
    end
    n_cmp++;
    if (saw_active !== 1'b1) begin
      n_bad++;
      $display("FAIL %s rx_transfer_active_during got %b expected 1", name, saw_active);
    end
  endtask

  task automatic test_reset();
    bus.dplus_in         = 1'b1;
    bus.dminus_in        = 1'b0;
    bus.buffer_occupancy = 7'd0;
    n_rst                = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.rx_packet_data, bus.store_rx_packet_data, bus.flush, bus.rx_error,
         bus.rx_transfer_active, bus.rx_data_ready, bus.rx_packet} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset outputs got %h/%b%b%b%b%b/%b expected all zero",
               bus.rx_packet_data, bus.store_rx_packet_data, bus.flush, bus.rx_error,
               bus.rx_transfer_active, bus.rx_data_ready, bus.rx_packet);
    end
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.rx_error, bus.rx_transfer_active, bus.rx_data_ready, bus.rx_packet} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_idle status got %b%b%b/%b expected 000/0000",
               bus.rx_error, bus.rx_transfer_active, bus.rx_data_ready, bus.rx_packet);
    end
    exp_packet = 4'b0000;
  endtask

  task automatic test_out_packet();
    pay_q = '{8'h19, 8'h0F};
    run_packet("out_packet", 4'b0001, 4'b1110, 5, 0, 1'b0, 2, 7'd0);
  endtask

  task automatic test_data0_flush();
    pay_q = '{8'h00, 8'h01, 8'h02};
    run_packet("data0_flush", 4'b0011, 4'b1100, 6, 0, 1'b0, 2, 7'd5);
  endtask

  task automatic test_bit_stuffing();
    pay_q = '{8'hFF, 8'h3F};
    run_packet("stuffed", 4'b0001, 4'b1110, 5, 0, 1'b0, 2, 7'd0);
    run_packet("stuff_missing", 4'b0001, 4'b1110, 5, 0, 1'b1, 2, 7'd0);
  endtask

  task automatic test_bad_pid();
    pay_q = '{8'hA5, 8'h3C};
    run_packet("bad_pid", 4'b0001, 4'b0000, 5, 0, 1'b0, 2, 7'd0);
  endtask

  task automatic test_boundaries();
    pay_q = '{8'h5A};
    run_packet("partial_eop", 4'b1011, 4'b0100, 5, 3, 1'b0, 2, 7'd0);
    pay_q = '{8'h12, 8'h34};
    run_packet("overflow_full", 4'b0011, 4'b1100, 5, 0, 1'b0, 2, 7'd64);
    pay_q.delete();
    run_packet("ack_recovers", 4'b0010, 4'b1101, 5, 0, 1'b0, 2, 7'd0);
    pay_q = '{8'h77};
    run_packet("short_eop", 4'b1001, 4'b0110, 5, 0, 1'b0, 1, 7'd0);
    pay_q = '{8'h01};
    run_packet("nak_payload", 4'b1010, 4'b0101, 5, 0, 1'b0, 2, 7'd0);
    pay_q.delete();
    for (int i = 0; i < MAX_BYTES + 1; i++) pay_q.push_back(8'($urandom));
    run_packet("max_bytes", 4'b1011, 4'b0100, 7, 0, 1'b0, 2, 7'd0);
  endtask

  task automatic test_reset_mid_packet();
    pay_q = '{8'hA5, 8'h5A, 8'hC3};
    build_packet(4'b0011, 4'b1100, 5, 0, 1'b0, 2, 7'd0);
    bus.buffer_occupancy = 7'd0;
    drive_lines(34);                       // stops inside the second byte
    got_q.delete();
    #2 n_rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.store_rx_packet_data, bus.rx_error, bus.rx_transfer_active,
         bus.rx_data_ready, bus.rx_packet, bus.rx_packet_data} !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_mid outputs got %b%b%b%b/%b/%h expected all zero",
               bus.store_rx_packet_data, bus.rx_error, bus.rx_transfer_active,
               bus.rx_data_ready, bus.rx_packet, bus.rx_packet_data);
    end
    bus.dplus_in  = 1'b1;
    bus.dminus_in = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_mid strobes got %0d expected 0", got_q.size());
    end
    exp_packet = 4'b0000;
  endtask

  task automatic test_random();
    logic [3:0] pid;
    logic [3:0] chk;
    logic [6:0] occ;
    int         len;
    bit         hs;
    for (int n = 0; n < 40; n++) begin
      pid = VALID_PIDS[$urandom_range(0, 6)];
      chk = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ~pid;
      hs  = (pid == 4'b0010) || (pid == 4'b1010) || (pid == 4'b1110);
      len = hs ? 0 : $urandom_range(0, 8);
      pay_q.delete();
      repeat (len) pay_q.push_back(8'($urandom));
      if ($urandom_range(0, 7) == 0)      occ = 7'd64;
      else if ($urandom_range(0, 3) == 0) occ = 7'd0;
      else                                occ = 7'($urandom_range(1, 63));
      run_packet("random", pid, chk, $urandom_range(5, 7), 0, 1'b0,
                 $urandom_range(2, 3), occ);
    end
  endtask

  initial begin
    test_reset();
    test_out_packet();
    test_data0_flush();
    test_bit_stuffing();
    test_bad_pid();
    test_boundaries();
    test_reset_mid_packet();
    test_random();
    test_out_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usb_rx_core.md
Name: usb_rx_core

Overview:
- USB full-speed-style packet receiver. It decodes the NRZI, bit-stuffed D+/D- line pair at one bit per clock and recovers SYNC, PID, payload bytes and EOP.
- It pushes payload bytes to the downstream RX FIFO and reports the packet type, completion and errors to the protocol controller.
- It sits between the USB pad inputs and the RX data buffer.

Parameters:
- MAX_BYTES, 64, maximum payload bytes per packet (matches the FIFO depth).

Ports:
- clk  in  1  system clock; one USB bit time per rising edge.
- n_rst  in  1  asynchronous active-low reset.
- dplus_in  in  1  D+ line, synchronous to clk, no internal synchronizer.
- dminus_in  in  1  D- line, synchronous to clk.
- buffer_occupancy  in  7  current RX FIFO byte count, 0..64.
- rx_packet_data  out  8  last completed payload byte.
- store_rx_packet_data  out  1  one-cycle FIFO write strobe for rx_packet_data.
- flush  out  1  one-cycle FIFO clear request.
- rx_error  out  1  packet error flag (level).
- rx_transfer_active  out  1  high while a packet is being received.
- rx_data_ready  out  1  valid packet completed (level).
- rx_packet  out  4  PID of the last valid packet.

Behaviour:
- Reset (async, n_rst=0): all outputs 0, rx_packet=0000, FSM=IDLE, previous-line register=J (D+=1, D-=0).
- Line states: J = 1/0, K = 0/1, SE0 = 0/0.
- NRZI decode, sampled each rising edge: decoded bit=1 if the line equals the previous sample, 0 if it changed.
- Bit unstuffing (PID/DATA states only):
  - after six consecutive decoded 1s, the next bit is discarded and must be 0;
  - a 1 in that position is a stuff error.
- FSM states: IDLE, SYNC, PID, DATA, EOP, ERR_WAIT.
- IDLE: on the first K, go to SYNC. Also on this transition: clear rx_error and rx_data_ready, set rx_transfer_active=1, pulse flush for one cycle if buffer_occupancy != 0.
- SYNC:
  - accept after at least five consecutive decoded 0s followed by a decoded 1; go to PID;
  - a 1 before five 0s, or SE0, is an error.
- PID:
  - receive 8 bits LSB first: bits[3:0]=PID, bits[7:4] must equal ~PID;
  - PID must be one of OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110;
  - on success, rx_packet<=PID; go to DATA;
  - on failure, error.
- DATA:
  - assemble bytes LSB first;
  - on each 8th non-stuffed bit, register rx_packet_data and pulse store_rx_packet_data for one cycle, both at the edge after the last bit is sampled;
  - CRC bits are treated as payload and forwarded unchecked (CRC validation belongs to the protocol layer);
  - handshake PIDs (ACK/NAK/STALL) expect zero payload bytes.
- DATA to EOP: SE0 moves to EOP.
  - SE0 with a partial byte (1-7 bits accumulated) is an error.
  - A byte completing while buffer_occupancy==64, or while MAX_BYTES bytes have already been stored, is an overflow error; no strobe is issued for that byte.
- EOP:
  - requires SE0 for at least 2 consecutive cycles followed by J;
  - then rx_data_ready<=1, rx_transfer_active<=0, return to IDLE;
  - SE0 for only 1 cycle followed by J/K is an error.
- Error (any state): rx_error<=1, rx_transfer_active<=0, rx_data_ready stays 0, rx_packet keeps its last value; go to ERR_WAIT.
- ERR_WAIT: wait for SE0 then J, or for 8 consecutive J samples, then IDLE.
- rx_error, rx_data_ready and rx_packet hold until the next packet start.
- Reset mid-packet: immediate return to reset values; no strobe is issued.
- Simultaneous stuff error and byte completion: error wins; no strobe.

Test Plan:
- Reset: hold n_rst=0 for 2 cycles with lines idle J -> all outputs 0, rx_packet=0000.
- Line sequence: SYNC (5x'0', '1'), PID OUT (0001/1110 LSB first), bytes 0x19, 0x0F, EOP (SE0 2 cycles, J); buffer_occupancy=0.
  - -> two store strobes with rx_packet_data 0x19 then 0x0F;
  - -> flush never asserted;
  - -> rx_transfer_active=1 until EOP;
  - -> afterwards rx_data_ready=1, rx_packet=0001, rx_error=0.
- DATA0 packet of bytes 0x00, 0x01, 0x02 with buffer_occupancy=5 -> one flush pulse at packet start; three strobes; rx_packet=0011.
- Payload byte 0xFF followed by 0x3F -> a stuffed 0 is inserted after the sixth 1 and is discarded; data bytes are received correctly.
  - Variant: omit the stuffed 0 -> rx_error=1, rx_transfer_active=0.
- PID 0001 with check nibble 0000 -> rx_error=1, no strobes, rx_packet unchanged.
- Boundary cases:
  - EOP after 3 bits of a byte -> rx_error=1;
  - buffer_occupancy=64 when a byte completes -> rx_error=1, no strobe;
  - a subsequent valid ACK packet clears rx_error and sets rx_data_ready=1, rx_packet=0010.
